// File: rtl/hd_ingress_if.sv
// Source-side and decoder-side signals of the HD ingress arbiter.
// The arbiter connects through the master modport; the sources and the decoder use slave.
interface hd_ingress_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_PORTS-1:0]            src_req;
    logic [NUM_PORTS-1:0]            src_sop;
    logic [NUM_PORTS-1:0]            src_eop;
    logic [NUM_PORTS-1:0]            src_vld;
    logic [NUM_PORTS*DATA_WIDTH-1:0] src_data;
    logic [NUM_PORTS-1:0]            src_gnt;
    logic [NUM_PORTS-1:0]            retx_req;
    logic                            hd_sop;
    logic                            hd_eop;
    logic                            hd_vld;
    logic [DATA_WIDTH-1:0]           hd_data;
    logic                            hd_error;
    logic                            hd_data_vld;

    modport master (
        input  src_req, src_sop, src_eop, src_vld, src_data, hd_error, hd_data_vld,
        output src_gnt, retx_req, hd_sop, hd_eop, hd_vld, hd_data
    );

    modport slave (
        output src_req, src_sop, src_eop, src_vld, src_data, hd_error, hd_data_vld,
        input  src_gnt, retx_req, hd_sop, hd_eop, hd_vld, hd_data
    );
endinterface

// File: rtl/hd_ingress_arbiter.sv
// Round-robin arbiter that lets NUM_PORTS packet sources share one HD decoder,
// with SOP timeout, overflow flush and retransmit requests on decoder errors.
module hd_ingress_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  gnt,
    input  logic                  sop,
    input  logic                  eop,
    input  logic                  vld,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  m_vld,
    output logic [DATA_WIDTH-1:0] m_data
);
    assign m_sop  = gnt & sop;
    assign m_eop  = gnt & eop;
    assign m_vld  = gnt & vld;
    assign m_data = data & {DATA_WIDTH{gnt}};
endmodule

module hd_ingress_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_WORDS   = 64,
    parameter int SOP_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    hd_ingress_if.master        bus,
    output logic                busy,
    output logic [7:0]          err_cnt
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = (SOP_TIMEOUT > 4) ? $clog2(SOP_TIMEOUT) + 1 : 3;

    typedef enum logic [2:0] {IDLE, GRANT, XFER, FLUSH, RESULT} state_t;

    state_t                               state, state_nxt;
    logic [PW-1:0]                        gnt_idx, last_port, pick, cand;
    logic                                 found, armed, fail, ovf, fwd;
    logic [TW-1:0]                        tmr;
    logic [6:0]                           word_cnt;
    logic                                 err_seen;
    logic [NUM_PORTS-1:0]                 gnt_oh, src_gnt, retx_q;
    logic [NUM_PORTS-1:0]                 m_sop, m_eop, m_vld;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] m_data;
    logic                                 g_sop, g_eop, g_vld;
    logic [DATA_WIDTH-1:0]                g_data, hd_data_q;
    logic                                 hd_sop_q, hd_eop_q, hd_vld_q;

    assign busy    = (state != IDLE);
    assign gnt_oh  = NUM_PORTS'(1) << gnt_idx;
    assign src_gnt = busy ? gnt_oh : '0;

    // Each lane masks its source with its grant bit, so non-granted strobes never reach the mux.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        hd_ingress_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .gnt    (src_gnt[i]),
            .sop    (bus.src_sop[i]),
            .eop    (bus.src_eop[i]),
            .vld    (bus.src_vld[i]),
            .data   (bus.src_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .m_sop  (m_sop[i]),
            .m_eop  (m_eop[i]),
            .m_vld  (m_vld[i]),
            .m_data (m_data[i])
        );
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) g_data = g_data | m_data[i];
        g_sop = |m_sop;
        g_eop = |m_eop;
        g_vld = |m_vld;
    end

    // Round-robin search starts one past the last granted port.
    always_comb begin
        found = 1'b0;
        pick  = last_port;
        cand  = last_port;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(last_port) + i) % NUM_PORTS);
            if (!found && bus.src_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fail      = 1'b0;
        ovf       = (state == XFER) && g_vld && (word_cnt == 7'(MAX_WORDS));
        case (state)
            IDLE:   if (armed && found) state_nxt = GRANT;
            GRANT: begin
                if (g_sop)
                    state_nxt = g_eop ? RESULT : XFER;
                else if (!bus.src_req[gnt_idx] || tmr == TW'(SOP_TIMEOUT - 1))
                    state_nxt = IDLE;
            end
            XFER: begin
                if (ovf)        state_nxt = FLUSH;
                else if (g_eop) state_nxt = RESULT;
            end
            FLUSH: begin
                state_nxt = IDLE;
                fail      = 1'b1;
            end
            RESULT: begin
                if (bus.hd_data_vld) begin
                    state_nxt = IDLE;
                    fail      = err_seen | bus.hd_error;
                end else if (tmr == TW'(3)) begin
                    state_nxt = IDLE;
                    fail      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The SOP word is seen while still in GRANT; a later SOP inside XFER is not forwarded.
        fwd = (state == GRANT && g_sop) || (state == XFER && !ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            last_port <= PW'(NUM_PORTS - 1);
            gnt_idx   <= '0;
            tmr       <= '0;
            word_cnt  <= '0;
            err_seen  <= 1'b0;
            err_cnt   <= '0;
            retx_q    <= '0;
            hd_sop_q  <= 1'b0;
            hd_eop_q  <= 1'b0;
            hd_vld_q  <= 1'b0;
            hd_data_q <= '0;
        end else begin
            armed <= 1'b1;
            state <= state_nxt;
            tmr   <= (state_nxt != state) ? '0 : tmr + TW'(1);
            if (state == IDLE && state_nxt == GRANT) gnt_idx <= pick;
            if (state == GRANT && state_nxt != GRANT) last_port <= gnt_idx;
            if (state == GRANT)
                word_cnt <= 7'(g_vld);
            else if (state == XFER && g_vld && !ovf)
                word_cnt <= word_cnt + 7'd1;
            if (state == GRANT)
                err_seen <= 1'b0;
            else if ((state == XFER || state == RESULT) && bus.hd_error)
                err_seen <= 1'b1;
            retx_q <= fail ? gnt_oh : '0;
            if (fail && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            hd_sop_q  <= (state == GRANT) && g_sop;
            hd_eop_q  <= (fwd && g_eop) || ovf;
            hd_vld_q  <= fwd && g_vld;
            hd_data_q <= fwd ? g_data : '0;
        end
    end

    assign bus.src_gnt  = src_gnt;
    assign bus.retx_req = retx_q;
    assign bus.hd_sop   = hd_sop_q;
    assign bus.hd_eop   = hd_eop_q;
    assign bus.hd_vld   = hd_vld_q;
    assign bus.hd_data  = hd_data_q;
endmodule

// File: tb/tb_hd_ingress_arbiter.sv
// Bench for hd_ingress_arbiter: sources and decoder are driven on the falling edge,
// forwarded words are checked against a queue of expected words with their cycle stamps.
module tb_hd_ingress_arbiter;
    localparam int NP   = 4;
    localparam int DW   = 16;
    localparam int MAXW = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] err_cnt;

    hd_ingress_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    hd_ingress_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_WORDS(MAXW), .SOP_TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sop;
        logic          eop;
        logic          vld;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0, passed = 0, cyc = 0;
    int   sop_seen = 0, retx_seen = 0, exp_err = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Every word reaching the decoder must be the next expected one, exactly one cycle late.
    initial forever begin
        @(negedge clk);
        if (!rst && bus.retx_req != '0) retx_seen++;
        if (!rst && (bus.hd_vld || bus.hd_sop || bus.hd_eop)) begin
            if (bus.hd_sop) sop_seen++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got sop=%b eop=%b vld=%b data=%h, required no decoder output",
                         bus.hd_sop, bus.hd_eop, bus.hd_vld, bus.hd_data);
            end else begin
                e_mon = sb.pop_front();
                if ({bus.hd_sop, bus.hd_eop, bus.hd_vld, bus.hd_data} !== {e_mon.sop, e_mon.eop, e_mon.vld, e_mon.data}
                    || cyc != e_mon.cyc + 1)
                    $display("FAIL sb_word: got sop=%b eop=%b vld=%b data=%h cyc=%0d, required sop=%b eop=%b vld=%b data=%h cyc=%0d",
                             bus.hd_sop, bus.hd_eop, bus.hd_vld, bus.hd_data, cyc,
                             e_mon.sop, e_mon.eop, e_mon.vld, e_mon.data, e_mon.cyc + 1);
                else
                    passed++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic drive_idle();
        bus.src_sop     = '0;
        bus.src_eop     = '0;
        bus.src_vld     = '0;
        bus.src_data    = '0;
        bus.hd_error    = 1'b0;
        bus.hd_data_vld = 1'b0;
    endtask

    task automatic wait_gnt(output int port);
        port = -1;
        for (int i = 0; i < 64; i++) begin
            if (bus.src_gnt != '0) begin
                for (int p = 0; p < NP; p++)
                    if (bus.src_gnt == (NP'(1) << p)) port = p;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_pkt(input int port, input int nwords, input int err_at,
                            input bit ack, input bit ack_err, input bit drop);
        int            got;
        bit            exp_fail;
        logic [DW-1:0] d;
        logic [NP-1:0] exp_retx;
        exp_t          e;
        wait_gnt(got);
        checks++;
        if (got != port) begin
            $display("FAIL grant_port: got %0d, required %0d", got, port);
            drive_idle();
            bus.src_req = '0;
            return;
        end
        passed++;
        exp_fail = (err_at >= 0) || ack_err || !ack || (nwords > MAXW);
        for (int w = 0; w < nwords; w++) begin
            d = DW'($urandom);
            bus.src_sop = '0; bus.src_eop = '0; bus.src_vld = '0; bus.src_data = '0;
            bus.src_sop[port] = (w == 0);
            bus.src_eop[port] = (w == nwords - 1);
            bus.src_vld[port] = 1'b1;
            bus.src_data[port*DW +: DW] = d;
            bus.hd_error = (w == err_at);
            e.sop = (w == 0); e.eop = (w == nwords - 1); e.vld = 1'b1; e.data = d; e.cyc = cyc;
            if (w == MAXW) begin
                e.sop = 1'b0; e.eop = 1'b1; e.vld = 1'b0; e.data = '0;
            end
            if (w <= MAXW) sb.push_back(e);
            @(negedge clk);
        end
        drive_idle();
        if (drop) bus.src_req = '0;
        if (ack) begin
            bus.hd_data_vld = 1'b1;
            bus.hd_error    = ack_err;
            @(negedge clk);
            bus.hd_data_vld = 1'b0;
            bus.hd_error    = 1'b0;
        end
        for (int i = 0; i < 8 && busy; i++) @(negedge clk);
        if (exp_fail && exp_err < 255) exp_err++;
        exp_retx = exp_fail ? (NP'(1) << port) : '0;
        checks++;
        if (bus.retx_req !== exp_retx)
            $display("FAIL retx_pulse: got %b, required %b (port %0d)", bus.retx_req, exp_retx, port);
        else passed++;
        checks++;
        if (err_cnt !== 8'(exp_err))
            $display("FAIL err_cnt: got %0d, required %0d", err_cnt, exp_err);
        else passed++;
        checks++;
        if (busy !== 1'b0 || bus.src_gnt !== '0)
            $display("FAIL dead_cycle: got busy=%b gnt=%b, required 0/0000", busy, bus.src_gnt);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.retx_req !== '0)
            $display("FAIL retx_width: got %b one cycle later, required 0000", bus.retx_req);
        else passed++;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.src_req = 4'b1111;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.src_gnt, bus.retx_req, bus.hd_sop, bus.hd_eop, bus.hd_vld, bus.hd_data, busy, err_cnt} !== '0)
            $display("FAIL reset_outputs: got gnt=%b retx=%b busy=%b err_cnt=%0d, required all 0",
                     bus.src_gnt, bus.retx_req, busy, err_cnt);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.src_gnt !== '0)
            $display("FAIL first_edge_grant: got %b, required 0000", bus.src_gnt);
        else passed++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) send_pkt(order[k], 3, -1, 1'b1, 1'b0, k == 4);
    endtask

    task automatic test_sop_timeout();
        int got, n, sop_base;
        rst = 1'b1;
        drive_idle();
        bus.src_req = 4'b1100;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        sop_base = sop_seen;
        wait_gnt(got);
        checks++;
        if (got != 2) $display("FAIL timeout_grant: got %0d, required 2", got);
        else passed++;
        n = 0;
        while (bus.src_gnt == 4'b0100 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) $display("FAIL timeout_len: got %0d grant cycles, required 16", n);
        else passed++;
        checks++;
        if (bus.src_gnt !== '0 || sop_seen != sop_base)
            $display("FAIL timeout_quiet: got gnt=%b hd_sop count=%0d, required 0000 and 0",
                     bus.src_gnt, sop_seen - sop_base);
        else passed++;
        send_pkt(3, 2, -1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_hd_error();
        bus.src_req = 4'b0010;
        send_pkt(1, 8, 5, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        bus.src_req = 4'b0001;
        send_pkt(0, MAXW + 1, -1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int            got, retx_base;
        logic [DW-1:0] d;
        exp_t          e;
        bus.src_req = 4'b0010;
        wait_gnt(got);
        checks++;
        if (got != 1) $display("FAIL mid_grant: got %0d, required 1", got);
        else passed++;
        for (int w = 0; w < 10; w++) begin
            d = DW'($urandom);
            bus.src_sop = '0; bus.src_vld = '0; bus.src_data = '0;
            bus.src_sop[1] = (w == 0);
            bus.src_vld[1] = 1'b1;
            bus.src_data[DW +: DW] = d;
            e.sop = (w == 0); e.eop = 1'b0; e.vld = 1'b1; e.data = d; e.cyc = cyc;
            sb.push_back(e);
            @(negedge clk);
        end
        bus.src_sop = '0;
        bus.src_data[DW +: DW] = DW'($urandom);
        retx_base = retx_seen;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.src_gnt, bus.retx_req, bus.hd_sop, bus.hd_eop, bus.hd_vld, bus.hd_data, busy, err_cnt} !== '0
            || sb.size() != 0)
            $display("FAIL mid_reset_outputs: got gnt=%b retx=%b eop=%b busy=%b err_cnt=%0d pending=%0d, required all 0",
                     bus.src_gnt, bus.retx_req, bus.hd_eop, busy, err_cnt, sb.size());
        else passed++;
        drive_idle();
        bus.src_req = 4'b0011;
        exp_err = 0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.src_gnt !== '0) $display("FAIL mid_first_edge: got %b, required 0000", bus.src_gnt);
        else passed++;
        send_pkt(0, 2, -1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (retx_seen != retx_base)
            $display("FAIL mid_no_retx: got %0d pulses, required 0", retx_seen - retx_base);
        else passed++;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 300; k++) begin
            bus.src_req = 4'b0001;
            send_pkt(0, 2, -1, 1'b1, 1'b1, 1'b1);
        end
        checks++;
        if (err_cnt !== 8'd255) $display("FAIL err_saturate: got %0d, required 255", err_cnt);
        else passed++;
    endtask

    initial begin
        drive_idle();
        bus.src_req = '0;
        test_reset();
        test_round_robin();
        test_sop_timeout();
        test_hd_error();
        test_overflow();
        test_reset_mid();
        test_saturation();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending words, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
